// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin arbiter that gives one requester at a time
// write access to a shared register. An owner keeps the grant while it
// holds its request, up to HOLD_MAX consecutive cycles. After that the
// grant is taken away and timeout pulses. Every grant is followed by one
// RELEASE cycle and one IDLE arbitration cycle. All outputs are flops.
module rr_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic [WIDTH-1:0]          q,
  output logic                      timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   hold_cnt;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   next_ptr;
  logic [NREQ-1:0] winner_onehot;

  // Pick the first active request at or above ptr, wrapping around.
  always_comb begin
    int idx;
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    winner = '0;
    idx    = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      // Scanning downward means the last hit, the one closest to ptr, wins.
      if (req[idx]) winner = IW'(idx);
    end
  end

  // One-hot form of the winner and the pointer value used on any GRANT exit.
  always_comb begin
    winner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << winner;
    next_ptr      = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  // Arbitration FSM together with the shared register and all output flops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then see the values from before the edge, whatever order the
    // statements below are written in.
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      q        <= '0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          gnt <= '0;
          if (req != '0) begin
            state    <= GRANT;
            owner    <= winner;
            gnt      <= winner_onehot;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (req[owner]) begin
            q <= wdata[int'(owner)*WIDTH +: WIDTH];
            if (hold_cnt == CW'(HOLD_MAX - 1)) begin
              // Forced release: the owner used its whole time slot.
              state   <= RELEASE;
              gnt     <= '0;
              timeout <= 1'b1;
              ptr     <= next_ptr;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else begin
            // Voluntary release: the owner dropped its request.
            state <= RELEASE;
            gnt   <= '0;
            ptr   <= next_ptr;
          end
        end
        RELEASE: begin
          state <= IDLE;
          gnt   <= '0;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Self-checking bench for rr_reg_arbiter (NREQ=4, WIDTH=8, HOLD_MAX=8).
// A table of {inputs, expected outputs} covers reset, a single requester,
// ptr wrap, round-robin order and a reset in the middle of a grant. Loops
// cover the timeout behaviour. Expected values are queued when stimulus
// is driven and compared 1 ns after the clock edge.
module tb_rr_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wd;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic        to;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic [7:0] q;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  rr_reg_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_MAX(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .owner   (owner),
    .q       (q),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mkexp(input logic [3:0] g, input logic [1:0] o,
                                 input logic [7:0] qq, input logic t);
    exp_t e;
    e.gnt = g; e.owner = o; e.q = qq; e.to = t;
    return e;
  endfunction

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                     input logic [3:0] g, input logic [1:0] o, input logic [7:0] qq,
                     input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.wd = wd; v.gnt = g; v.owner = o; v.q = qq; v.to = t;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic drive(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                       input exp_t e, input string tag);
    exp_t x;
    rst = r; req = rq; wdata = wd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check({tag, " gnt"},     32'(gnt),     32'(x.gnt));
      check({tag, " owner"},   32'(owner),   32'(x.owner));
      check({tag, " q"},       32'(q),       32'(x.q));
      check({tag, " timeout"}, 32'(timeout), 32'(x.to));
      check({tag, " onehot"},  32'($countones(gnt) <= 1), 32'd1);
    end
  endtask

  // Requester 0 always requests. If r[1] is set, requester 1 also requests
  // and must win the arbitration right after the forced release.
  task automatic run_timeout(input logic [3:0] r, input int ncyc, input string tag);
    int p;
    int ghigh;
    int tos;
    logic [3:0] eg;
    logic [1:0] eo;
    logic [7:0] eq;
    ghigh = 0;
    tos   = 0;
    for (int c = 0; c < ncyc; c++) begin
      p  = c % 10;
      eo = (c >= 10 && r[1]) ? 2'd1 : 2'd0;
      eg = (p <= 7) ? ((c >= 10 && r[1]) ? 4'b0010 : 4'b0001) : 4'b0000;
      if (p >= 1 && p <= 8) eq = 8'(c + 1);
      else if (p == 9)      eq = 8'(c);
      else                  eq = (c == 0) ? 8'h00 : 8'(c - 1);
      drive(1'b0, r, {16'h0000, 8'hEE, 8'(c + 1)}, mkexp(eg, eo, eq, p == 8),
            $sformatf("%s c%0d", tag, c));
      if (c < 10) begin
        if (gnt[0]) ghigh++;
        if (timeout) tos++;
      end
    end
    check({tag, " gnt0 cycles"},  32'(ghigh), 32'd8);
    check({tag, " timeout pulses"}, 32'(tos), 32'd1);
  endtask

  localparam logic [31:0] W = 32'h7CA5_6B5A;
  localparam logic [31:0] F = 32'hFFFF_FFFF;
  localparam logic [31:0] D = 32'h4433_2211;

  initial begin
    logic [7:0] prev;
    logic [7:0] vk;
    rst = 1'b1; req = 4'b1111; wdata = W;

    // Reset with every request active.
    add(1, 4'b1111, W, 4'b0000, 0, 8'h00, 0);
    add(1, 4'b1111, W, 4'b0000, 0, 8'h00, 0);
    // Single requester 2 for three cycles, then it drops the request.
    add(0, 4'b0100, W, 4'b0100, 2, 8'h00, 0);
    add(0, 4'b0100, W, 4'b0100, 2, 8'hA5, 0);
    add(0, 4'b0100, W, 4'b0100, 2, 8'hA5, 0);
    add(0, 4'b0000, W, 4'b0000, 2, 8'hA5, 0);
    add(0, 4'b0000, W, 4'b0000, 2, 8'hA5, 0);
    add(0, 4'b0000, W, 4'b0000, 2, 8'hA5, 0);
    // ptr is now 3; the scan wraps and requester 0 wins. A voluntary release writes nothing.
    add(0, 4'b0011, W, 4'b0001, 0, 8'hA5, 0);
    add(0, 4'b0000, W, 4'b0000, 0, 8'hA5, 0);
    add(0, 4'b0000, W, 4'b0000, 0, 8'hA5, 0);
    // Round robin from ptr=0: one write per owner, drop req, re-raise it in RELEASE.
    add(1, 4'b0000, F, 4'b0000, 0, 8'h00, 0);
    prev = 8'h00;
    for (int k = 0; k < 4; k++) begin
      vk = 8'(8'h11 * (k + 1));
      add(0, 4'b1111, F, 4'(1 << k), 2'(k), prev, 0);
      add(0, 4'b1111, D, 4'(1 << k), 2'(k), vk, 0);
      add(0, 4'b1111 & ~4'(1 << k), F, 4'b0000, 2'(k), vk, 0);
      add(0, 4'b1111, F, 4'b0000, 2'(k), vk, 0);
      prev = vk;
    end
    add(0, 4'b1111, F, 4'b0001, 0, 8'h44, 0);
    add(0, 4'b0000, F, 4'b0000, 0, 8'h44, 0);
    add(0, 4'b0000, F, 4'b0000, 0, 8'h44, 0);
    // Reset in owner 2's second GRANT cycle: no write, then arbitration restarts at ptr=0.
    add(0, 4'b0100, F, 4'b0100, 2, 8'h44, 0);
    add(0, 4'b0100, 32'h0099_0000, 4'b0100, 2, 8'h99, 0);
    add(1, 4'b0100, 32'h00EE_0000, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0000, F, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0110, F, 4'b0010, 1, 8'h00, 0);
    add(0, 4'b0000, F, 4'b0000, 1, 8'h00, 0);
    add(0, 4'b0000, F, 4'b0000, 1, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].wd,
            mkexp(vecs[i].gnt, vecs[i].owner, vecs[i].q, vecs[i].to),
            $sformatf("vec%0d", i));
    end

    // Timeout with a lone requester, then with requester 1 also waiting.
    drive(1'b1, 4'b0000, 32'h0, mkexp(4'b0000, 0, 8'h00, 0), "rst_to1");
    run_timeout(4'b0001, 20, "to_single");
    drive(1'b1, 4'b0000, 32'h0, mkexp(4'b0000, 0, 8'h00, 0), "rst_to2");
    run_timeout(4'b0011, 11, "to_pair");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rr_reg_arbiter.md
RR_REG_ARBITER -- requirements
Module: rr_reg_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL give the number of requesters; the supported range is 2..8.
REQ-002 Parameter WIDTH, default 8, SHALL give the width of the shared register.
REQ-003 Parameter HOLD_MAX, default 8, SHALL give the maximum number of consecutive GRANT cycles per owner; the supported range is 2..255.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 req  input  NREQ  SHALL carry the per-requester access requests; bit i belongs to requester i.
REQ-007 wdata  input  NREQ*WIDTH  SHALL carry the write data; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-008 gnt  output  NREQ  SHALL be the grant vector, one-hot or all zero, registered.
REQ-009 owner  output  clog2(NREQ)  SHALL hold the index of the current or most recent grantee, registered.
REQ-010 q  output  WIDTH  SHALL be the shared register contents, registered.
REQ-011 timeout  output  1  SHALL pulse for one cycle on a forced release.

Function
REQ-012 The FSM SHALL have three states, IDLE, GRANT and RELEASE, and no others; any illegal encoding SHALL go to IDLE on the next clk edge.
REQ-013 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0 and q held.
REQ-014 In IDLE with req!=0, the winner SHALL be the first set req bit found by scanning from index ptr upward, with wrap from NREQ-1 to 0.
REQ-015 On the edge that leaves IDLE, the block SHALL set state=GRANT, owner=winner, gnt=onehot(winner) and hold_cnt=0, so gnt rises one cycle after the req sample.
REQ-016 In GRANT, on each edge with req[owner]=1, q SHALL load wdata[owner] and hold_cnt SHALL increment; q therefore lags wdata by one cycle.
REQ-017 In GRANT, an edge with req[owner]=0 SHALL move the FSM to RELEASE, clear gnt and leave q unchanged; this is a voluntary release.
REQ-018 In GRANT, an edge with req[owner]=1 and hold_cnt==HOLD_MAX-1 SHALL perform that cycle's write, then move to RELEASE, clear gnt and assert timeout for exactly the following cycle; this is a forced release.
REQ-019 Every exit from GRANT SHALL set ptr=(owner+1) mod NREQ.
REQ-020 RELEASE SHALL last exactly one cycle with gnt=0 and then go to IDLE, giving a minimum of 2 dead cycles between grants.
REQ-021 While in GRANT, changes on req bits other than owner SHALL have no effect.
REQ-022 A requester whose request stays asserted after a forced release SHALL be treated as a new request and SHALL only win again once ptr reaches it.
REQ-023 q SHALL never be written outside GRANT.
REQ-024 At most one gnt bit SHALL be high on any cycle.
REQ-025 No requester with req held continuously SHALL wait more than (NREQ-1)*(HOLD_MAX+2)+2 cycles for gnt.
REQ-026 All outputs SHALL be driven directly from flops, with no combinational path from input to output.

Reset
REQ-027 With rst=1 at an edge, the block SHALL set state=IDLE, gnt=0, owner=0, q=0, timeout=0, ptr=0 and hold_cnt=0.
REQ-028 rst SHALL take priority over every other event, including a GRANT write on the same edge, so that no write occurs.
REQ-029 If rst is asserted mid-GRANT, the grant SHALL drop the cycle after the reset edge, with no RELEASE cycle and no timeout pulse.
REQ-030 After rst deasserts, the first arbitration SHALL use ptr=0.

Verification
REQ-031 The bench SHALL cover reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, q=0, owner=0, timeout=0 throughout.
REQ-032 The bench SHALL cover a single requester: req=4'b0100 with wdata[2]=8'hA5 for 3 cycles, then req=0 -> gnt=4'b0100 from cycle 2; q=8'hA5 from cycle 3; gnt=0 after release; q stays 8'hA5.
REQ-033 The bench SHALL cover round-robin: req=4'b1111 held, with each owner dropping req after 1 GRANT cycle and re-raising it in RELEASE -> grant order 0,1,2,3,0.
REQ-034 The bench SHALL cover timeout: req=4'b0001 held for 20 cycles, HOLD_MAX=8 -> gnt[0] high for exactly 8 cycles, then timeout=1 for 1 cycle and 2 dead cycles; with req=4'b0011 instead, requester 1 is granted next.
REQ-035 The bench SHALL cover the ptr wrap: ptr=3 with req=4'b0011 -> requester 0 wins.
REQ-036 The bench SHALL cover mid-grant reset: rst=1 on the 2nd GRANT cycle of owner 2 -> the next cycle shows gnt=0, q=0 and owner=0, and no write from that edge.
